// File: rtl/gpio_bank_emu.sv
// rtl/gpio_bank_emu.sv - GPIO bank register emulation behind asynchronous strobes
// Optional feature macro: GPIO_BANK_IRQ_EN (latch-rise interrupt status/mask and irq).
// Ports:
//   clk, n_reset                 - clock, asynchronous active-low reset
//   saddress, srd, swr, sdata_in - register address, async read/write strobes, write data
//   sdata_out, sack              - registered read data, one-cycle access-complete pulse
//   gpio_in, gpio_latch          - pin inputs and their async capture strobe
//   gpio_out, gpio_oe            - pin drive value and output enable
//   gpio_in_s_insp               - latched pin inputs
//   irq                          - level interrupt (0 unless GPIO_BANK_IRQ_EN)
module gpio_bank_emu #(
  parameter int unsigned GPIO_W     = 8,
  parameter int unsigned DATA_SHIFT = 8,
  parameter logic [7:0]  BASE_HI    = 8'h6B
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [15:0]       saddress,
  input  logic              srd,
  input  logic              swr,
  input  logic [31:0]       sdata_in,
  output logic [31:0]       sdata_out,
  output logic              sack,
  input  logic [GPIO_W-1:0] gpio_in,
  input  logic              gpio_latch,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_oe,
  output logic [GPIO_W-1:0] gpio_in_s_insp,
  output logic              irq
);

  if (GPIO_W < 1 || GPIO_W > 24 || GPIO_W + DATA_SHIFT > 32) begin : g_param_check
    $error("gpio_bank_emu: GPIO_W/DATA_SHIFT out of range");
  end

  // Synchronizers preset to 1 so a strobe held high across reset release
  // looks like "already high" and produces no edge until it toggles.
  logic [2:0] rd_sync, wr_sync, lt_sync;
  logic       rd_edge, wr_edge, lt_edge;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rd_sync <= 3'b111;
      wr_sync <= 3'b111;
      lt_sync <= 3'b111;
    end else begin
      rd_sync <= {rd_sync[1:0], srd};
      wr_sync <= {wr_sync[1:0], swr};
      lt_sync <= {lt_sync[1:0], gpio_latch};
    end
  end

  assign rd_edge = rd_sync[1] & ~rd_sync[2];
  assign wr_edge = wr_sync[1] & ~wr_sync[2];
  assign lt_edge = lt_sync[1] & ~lt_sync[2];

  logic              hit;
  logic [3:0]        sel;
  logic [GPIO_W-1:0] out_r, dir_r, in_s;
  logic [GPIO_W-1:0] wr_field, in_val, rd_field;
  logic [GPIO_W-1:0] irq_status, irq_mask;
  logic [31:0]       rd_word;
  logic              unused_bits;

  assign hit         = (saddress[15:8] == BASE_HI) && (saddress[3:0] == 4'h0);
  assign sel         = saddress[7:4];
  assign wr_field    = sdata_in[DATA_SHIFT +: GPIO_W];
  assign in_val      = (dir_r & out_r) | (~dir_r & in_s);
  assign unused_bits = ^sdata_in;

  always_comb begin
    rd_field = '0;
    if (hit) begin
      case (sel)
        4'd0:    rd_field = out_r;
        4'd1:    rd_field = in_val;
        4'd2:    rd_field = dir_r;
        4'd3:    rd_field = irq_status;
        4'd4:    rd_field = irq_mask;
        default: rd_field = '0;
      endcase
    end
  end

  always_comb begin
    rd_word = '0;
    rd_word[DATA_SHIFT +: GPIO_W] = rd_field;
  end

  // Read mux uses pre-write state, so a coincident read/write returns the old value.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      out_r     <= '0;
      dir_r     <= '0;
      in_s      <= '0;
      sdata_out <= '0;
      sack      <= 1'b0;
    end else begin
      sack <= rd_edge | wr_edge;
      if (rd_edge) sdata_out <= rd_word;
      if (wr_edge && hit && sel == 4'd0) out_r <= wr_field;
      if (wr_edge && hit && sel == 4'd2) dir_r <= wr_field;
      if (lt_edge) in_s <= gpio_in;
    end
  end

`ifdef GPIO_BANK_IRQ_EN
  logic [GPIO_W-1:0] rise, w1c;

  assign rise = lt_edge ? (gpio_in & ~in_s) : '0;
  assign w1c  = (wr_edge && hit && sel == 4'd3) ? wr_field : '0;

  // OR-ing rise after the clear lets a fresh capture win over a same-cycle W1C.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      irq_status <= '0;
      irq_mask   <= '0;
      irq        <= 1'b0;
    end else begin
      irq_status <= (irq_status & ~w1c) | rise;
      if (wr_edge && hit && sel == 4'd4) irq_mask <= wr_field;
      irq <= |(irq_status & irq_mask);
    end
  end
`else
  assign irq_status = '0;
  assign irq_mask   = '0;
  assign irq        = 1'b0;
`endif

  assign gpio_out       = out_r;
  assign gpio_oe        = dir_r;
  assign gpio_in_s_insp = in_s;

endmodule

// File: tb/tb_gpio_bank_emu.sv
// tb/tb_gpio_bank_emu.sv - self-checking bench for gpio_bank_emu
module tb_gpio_bank_emu;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic [15:0] saddress = 16'h0;
  logic        srd = 1'b0, swr = 1'b0, gpio_latch = 1'b0;
  logic [31:0] sdata_in = 32'h0;
  logic [7:0]  gpio_in = 8'h0;
  logic [31:0] sdata_out;
  logic        sack, irq;
  logic [7:0]  gpio_out, gpio_oe, gpio_in_s_insp;

  gpio_bank_emu dut (
    .clk(clk), .n_reset(n_reset), .saddress(saddress), .srd(srd), .swr(swr),
    .sdata_in(sdata_in), .sdata_out(sdata_out), .sack(sack), .gpio_in(gpio_in),
    .gpio_latch(gpio_latch), .gpio_out(gpio_out), .gpio_oe(gpio_oe),
    .gpio_in_s_insp(gpio_in_s_insp), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int sack_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference model: a rising strobe seen at clock n is serviced at clock n+2.
  bit [7:0]  m_out, m_dir, m_ins, m_stat, m_mask;
  bit [31:0] m_sdo;
  bit        m_sack, m_irq;
  bit        p_rd = 1'b1, p_wr = 1'b1, p_lt = 1'b1;
  int        rd_q[$], wr_q[$], lt_q[$];
  int        cyc = 0;

  always @(posedge clk or negedge n_reset) begin
    bit       rd_go, wr_go, lt_go, hit, nirq;
    bit [3:0] rsel;
    bit [7:0] field, rv, rise;
    if (!n_reset) begin
      m_out = 0; m_dir = 0; m_ins = 0; m_stat = 0; m_mask = 0;
      m_sdo = 0; m_sack = 0; m_irq = 0;
      p_rd = 1; p_wr = 1; p_lt = 1;
      rd_q.delete(); wr_q.delete(); lt_q.delete();
    end else begin
      cyc++;
      rd_go = 0; wr_go = 0; lt_go = 0;
      if (rd_q.size() > 0 && rd_q[0] == cyc) begin void'(rd_q.pop_front()); rd_go = 1; end
      if (wr_q.size() > 0 && wr_q[0] == cyc) begin void'(wr_q.pop_front()); wr_go = 1; end
      if (lt_q.size() > 0 && lt_q[0] == cyc) begin void'(lt_q.pop_front()); lt_go = 1; end
      hit   = (saddress[15:8] == 8'h6B) && (saddress[3:0] == 4'h0);
      rsel  = saddress[7:4];
      field = sdata_in[15:8];
      case (rsel)
        4'd0: rv = m_out;
        4'd1: rv = (m_dir & m_out) | (~m_dir & m_ins);
        4'd2: rv = m_dir;
`ifdef GPIO_BANK_IRQ_EN
        4'd3: rv = m_stat;
        4'd4: rv = m_mask;
`endif
        default: rv = 0;
      endcase
      if (!hit) rv = 0;
`ifdef GPIO_BANK_IRQ_EN
      nirq = |(m_stat & m_mask);
`else
      nirq = 0;
`endif
      if (rd_go) m_sdo = {16'h0, rv, 8'h0};
      m_sack = rd_go | wr_go;
      rise = lt_go ? (gpio_in & ~m_ins) : 8'h0;
      if (wr_go && hit) begin
        if (rsel == 0) m_out = field;
        if (rsel == 2) m_dir = field;
`ifdef GPIO_BANK_IRQ_EN
        if (rsel == 3) m_stat = m_stat & ~field;
        if (rsel == 4) m_mask = field;
`endif
      end
`ifdef GPIO_BANK_IRQ_EN
      m_stat = m_stat | rise;
`endif
      if (lt_go) m_ins = gpio_in;
      m_irq = nirq;
      if (srd && !p_rd) rd_q.push_back(cyc + 2);
      if (swr && !p_wr) wr_q.push_back(cyc + 2);
      if (gpio_latch && !p_lt) lt_q.push_back(cyc + 2);
      p_rd = srd; p_wr = swr; p_lt = gpio_latch;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("sdata_out", sdata_out, m_sdo);
    chk("sack", {31'h0, sack}, {31'h0, m_sack});
    chk("gpio_out", {24'h0, gpio_out}, {24'h0, m_out});
    chk("gpio_oe", {24'h0, gpio_oe}, {24'h0, m_dir});
    chk("gpio_in_s_insp", {24'h0, gpio_in_s_insp}, {24'h0, m_ins});
    chk("irq", {31'h0, irq}, {31'h0, m_irq});
    if (sack) sack_cnt++;
  end

  task automatic acc(input bit r, input bit w, input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    saddress = a; sdata_in = d; srd = r; swr = w;
    repeat (4) @(negedge clk);
    srd = 0; swr = 0;
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic latch();
    @(negedge clk);
    gpio_latch = 1;
    repeat (4) @(negedge clk);
    gpio_latch = 0;
    repeat (2) @(negedge clk);
    #1;
  endtask

  initial begin
    int lat, pulses, s0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset sdata_out", sdata_out, 32'h0);
    chk("reset sack", {31'h0, sack}, 32'h0);
    chk("reset gpio_out", {24'h0, gpio_out}, 32'h0);
    chk("reset gpio_oe", {24'h0, gpio_oe}, 32'h0);
    chk("reset irq", {31'h0, irq}, 32'h0);
    n_reset = 1;

    // Write latency: sack on the third clock counting the one that samples swr.
    @(negedge clk);
    saddress = 16'h6B00; sdata_in = 32'h0000_A500; swr = 1;
    lat = 0; pulses = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (sack) begin pulses++; if (lat == 0) lat = k; end
    end
    chk("write latency", lat, 3);
    chk("write sack pulses", pulses, 1);
    chk("write gpio_out", {24'h0, gpio_out}, 32'hA5);
    @(negedge clk); swr = 0;
    repeat (2) @(negedge clk);

    // IN read mixes driven and latched bits.
    acc(0, 1, 16'h6B20, 32'h0000_0F00);
    acc(0, 1, 16'h6B00, 32'h0000_0500);
    gpio_in = 8'h30;
    latch();
    acc(1, 0, 16'h6B10, 32'h0);
    chk("read IN", sdata_out, 32'h0000_3500);

    // Unmapped addresses.
    acc(1, 0, 16'h6B50, 32'h0);
    chk("read 6B50", sdata_out, 32'h0);
    acc(1, 0, 16'h6B10, 32'h0);
    s0 = sack_cnt;
    acc(1, 0, 16'h6C00, 32'h0);
    chk("read 6C00", sdata_out, 32'h0);
    acc(0, 1, 16'h6C00, 32'hFFFF_FFFF);
    acc(0, 1, 16'h6B50, 32'hFFFF_FFFF);
    acc(0, 1, 16'h6B04, 32'hFFFF_FFFF);
    chk("unmapped sack count", sack_cnt - s0, 4);
    chk("unmapped gpio_out", {24'h0, gpio_out}, 32'h05);
    chk("unmapped gpio_oe", {24'h0, gpio_oe}, 32'h0F);

    // Coincident read/write.
    acc(0, 1, 16'h6B20, 32'h0);
    s0 = sack_cnt;
    acc(1, 1, 16'h6B20, 32'h0000_FF00);
    chk("rw read old", sdata_out, 32'h0);
    chk("rw new DIR", {24'h0, gpio_oe}, 32'hFF);
    chk("rw single sack", sack_cnt - s0, 1);

`ifdef GPIO_BANK_IRQ_EN
    acc(0, 1, 16'h6B40, 32'h0000_0100);
    gpio_in = 8'h00; latch();
    gpio_in = 8'h01; latch();
    repeat (2) @(negedge clk); #1;
    chk("irq set", {31'h0, irq}, 32'h1);
    acc(0, 1, 16'h6B30, 32'h0000_0100);
    repeat (2) @(negedge clk); #1;
    chk("irq cleared", {31'h0, irq}, 32'h0);
    gpio_in = 8'h00; latch();
    gpio_in = 8'h01;
    @(negedge clk);
    saddress = 16'h6B30; sdata_in = 32'h0000_0100; swr = 1; gpio_latch = 1;
    repeat (4) @(negedge clk);
    swr = 0; gpio_latch = 0;
    repeat (3) @(negedge clk); #1;
    chk("irq set wins", {31'h0, irq}, 32'h1);
`else
    acc(0, 1, 16'h6B40, 32'h0000_FF00);
    acc(0, 1, 16'h6B30, 32'h0000_FF00);
    acc(1, 0, 16'h6B40, 32'h0);
    chk("mask reads 0", sdata_out, 32'h0);
    chk("irq tied 0", {31'h0, irq}, 32'h0);
`endif

    // Reset mid-access with swr held high through release.
    @(negedge clk);
    saddress = 16'h6B00; sdata_in = 32'h0000_5A00; swr = 1;
    @(negedge clk); #2 n_reset = 0;
    @(negedge clk); #1;
    chk("midrst gpio_out", {24'h0, gpio_out}, 32'h0);
    chk("midrst sdata_out", sdata_out, 32'h0);
    chk("midrst sack", {31'h0, sack}, 32'h0);
    s0 = sack_cnt;
    #1 n_reset = 1;
    repeat (6) @(negedge clk); #1;
    chk("held swr no write", {24'h0, gpio_out}, 32'h0);
    chk("held swr no sack", sack_cnt - s0, 0);
    @(negedge clk); swr = 0;
    repeat (2) @(negedge clk); swr = 1;
    repeat (4) @(negedge clk); swr = 0;
    repeat (2) @(negedge clk); #1;
    chk("toggled swr write", {24'h0, gpio_out}, 32'h5A);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] tbl [8];
      tbl = '{16'h6B00, 16'h6B10, 16'h6B20, 16'h6B30, 16'h6B40, 16'h6B50, 16'h6C00, 16'h6B04};
      @(negedge clk);
      if ($urandom_range(0, 2) == 0) srd = ~srd;
      if ($urandom_range(0, 2) == 0) swr = ~swr;
      if ($urandom_range(0, 2) == 0) gpio_latch = ~gpio_latch;
      if ($urandom_range(0, 3) == 0) saddress = tbl[$urandom_range(0, 7)];
      sdata_in = $urandom;
      gpio_in  = 8'($urandom);
      if (i % 400 == 399) begin
        #2 n_reset = 0;
        #2 n_reset = 1;
      end
    end
    srd = 0; swr = 0; gpio_latch = 0;
    repeat (5) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
